// File: rtl/spi_seq.sv
// Command sequencer in front of the SPI PHY: a CMD FIFO feeds one transfer at a time, and an RX FIFO collects captured words.
// Optional build macro SPI_SEQ_IRQ_EN adds rx_thresh_i / irq_o.
module spi_seq #(
    parameter  int MAXID = 4,
    parameter  int DEPTH = 8,
    localparam int CW    = (MAXID > 1) ? $clog2(MAXID) : 1,
    localparam int NW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
`ifdef SPI_SEQ_IRQ_EN
    input  logic [NW-1:0] rx_thresh_i,
    output logic          irq_o,
`endif
    input  logic          spi_clock_i,
    input  logic          spi_reset_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [CW-1:0] cmd_csid_i,
    input  logic [4:0]    cmd_tx_sz_i,
    input  logic [4:0]    cmd_rx_sz_i,
    input  logic          cmd_rx_en_i,
    input  logic [31:0]   cmd_data_i,
    output logic          rx_valid_o,
    input  logic          rx_pop_i,
    output logic [31:0]   rx_data_o,
    input  logic          flush_i,
    output logic [NW-1:0] cmd_count_o,
    output logic [NW-1:0] rx_count_o,
    output logic          idle_o,
    output logic          spi_tx_o,
    output logic [CW-1:0] spi_csid_o,
    output logic [4:0]    spi_tx_sz_o,
    output logic [4:0]    spi_rx_sz_o,
    output logic          spi_rx_en_o,
    output logic [31:0]   spi_tx_data_o,
    input  logic          spi_done_i,
    input  logic          spi_busy_i,
    input  logic [31:0]   spi_rx_i
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

    typedef struct packed {
        logic [CW-1:0] csid;
        logic [4:0]    tx_sz;
        logic [4:0]    rx_sz;
        logic          rx_en;
        logic [31:0]   data;
    } cmd_t;

    state_t state_q, state_d;

    cmd_t          cmd_mem [DEPTH];
    logic [31:0]   rx_mem  [DEPTH];
    logic [PW-1:0] cmd_wr_q, cmd_rd_q, rx_wr_q, rx_rd_q;
    logic [NW-1:0] cmd_cnt_q, cmd_cnt_d, rx_cnt_q, rx_cnt_d;

    logic [CW-1:0] spi_csid_q;
    logic [4:0]    spi_tx_sz_q, spi_rx_sz_q;
    logic          spi_rx_en_q;
    logic [31:0]   spi_data_q;

    cmd_t cmd_in, cmd_head;
    logic cmd_full, cmd_empty, rx_full, rx_empty;
    logic cmd_push, cmd_pop, rx_push, rx_pop, load;

    assign cmd_in    = {cmd_csid_i, cmd_tx_sz_i, cmd_rx_sz_i, cmd_rx_en_i, cmd_data_i};
    assign cmd_head  = cmd_mem[cmd_rd_q];
    assign cmd_full  = (cmd_cnt_q == NW'(DEPTH));
    assign cmd_empty = (cmd_cnt_q == '0);
    assign rx_full   = (rx_cnt_q == NW'(DEPTH));
    assign rx_empty  = (rx_cnt_q == '0);

    // The in-flight command stays at the CMD head until its done arrives.
    assign cmd_ready_o = !cmd_full && (state_q != S_DRAIN);
    assign cmd_push    = cmd_valid_i && cmd_ready_o && !flush_i;
    assign cmd_pop     = (state_q == S_WAIT) && spi_done_i && !flush_i;
    assign rx_push     = cmd_pop && spi_rx_en_q;
    assign rx_pop      = rx_pop_i && !rx_empty && !flush_i;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Issuing an rx_en command requires a free RX slot, so a capture never overflows.
                if (!flush_i && !cmd_empty && !spi_busy_i && (!cmd_head.rx_en || !rx_full)) begin
                    state_d = S_ISSUE;
                    load    = 1'b1;
                end
            end
            S_ISSUE: state_d = flush_i ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (spi_done_i)   state_d = S_IDLE;
                else if (flush_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (spi_done_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_cnt_d = cmd_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        if (flush_i) begin
            cmd_cnt_d = '0;
            rx_cnt_d  = '0;
        end else begin
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_cnt_d = cmd_cnt_q + NW'(1);
                2'b01:   cmd_cnt_d = cmd_cnt_q - NW'(1);
                default: cmd_cnt_d = cmd_cnt_q;
            endcase
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt_d = rx_cnt_q + NW'(1);
                2'b01:   rx_cnt_d = rx_cnt_q - NW'(1);
                default: rx_cnt_d = rx_cnt_q;
            endcase
        end
    end

    always_ff @(posedge spi_clock_i or negedge spi_reset_ni) begin
        if (!spi_reset_ni) begin
            state_q     <= S_IDLE;
            cmd_wr_q    <= '0;
            cmd_rd_q    <= '0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            cmd_cnt_q   <= '0;
            rx_cnt_q    <= '0;
            spi_csid_q  <= '0;
            spi_tx_sz_q <= '0;
            spi_rx_sz_q <= '0;
            spi_rx_en_q <= 1'b0;
            spi_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            cmd_cnt_q <= cmd_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            if (flush_i) begin
                cmd_wr_q <= '0;
                cmd_rd_q <= '0;
                rx_wr_q  <= '0;
                rx_rd_q  <= '0;
            end else begin
                if (cmd_push) cmd_wr_q <= cmd_wr_q + PW'(1);
                if (cmd_pop)  cmd_rd_q <= cmd_rd_q + PW'(1);
                if (rx_push)  rx_wr_q  <= rx_wr_q + PW'(1);
                if (rx_pop)   rx_rd_q  <= rx_rd_q + PW'(1);
            end
            if (load) begin
                spi_csid_q  <= cmd_head.csid;
                spi_tx_sz_q <= cmd_head.tx_sz;
                spi_rx_sz_q <= cmd_head.rx_sz;
                spi_rx_en_q <= cmd_head.rx_en;
                spi_data_q  <= cmd_head.data;
            end
        end
    end

    // Storage arrays carry no reset; occupancy and pointers define validity.
    always_ff @(posedge spi_clock_i) begin
        if (cmd_push) cmd_mem[cmd_wr_q] <= cmd_in;
        if (rx_push)  rx_mem[rx_wr_q]   <= spi_rx_i;
    end

    assign rx_valid_o    = !rx_empty;
    assign rx_data_o     = rx_mem[rx_rd_q];
    assign cmd_count_o   = cmd_cnt_q;
    assign rx_count_o    = rx_cnt_q;
    assign idle_o        = (state_q == S_IDLE) && cmd_empty;
    assign spi_tx_o      = (state_q == S_ISSUE);
    assign spi_csid_o    = spi_csid_q;
    assign spi_tx_sz_o   = spi_tx_sz_q;
    assign spi_rx_sz_o   = spi_rx_sz_q;
    assign spi_rx_en_o   = spi_rx_en_q;
    assign spi_tx_data_o = spi_data_q;

`ifdef SPI_SEQ_IRQ_EN
    logic irq_q, irq_d, done_seen_q;

    // Evaluated on next-state values so irq_o tracks the counts without an extra cycle of lag.
    always_comb begin
        irq_d = ((rx_thresh_i != '0) && (rx_cnt_d >= rx_thresh_i)) ||
                ((cmd_cnt_d == '0) && (state_d == S_IDLE) && (done_seen_q || cmd_pop));
    end

    always_ff @(posedge spi_clock_i or negedge spi_reset_ni) begin
        if (!spi_reset_ni) begin
            irq_q       <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            irq_q       <= irq_d;
            done_seen_q <= done_seen_q | cmd_pop;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_spi_seq.sv
// Directed bench for spi_seq: a cycle table for basic issue/capture, then hand sequences for
// fill/backpressure, RX reservation, flush/drain, async reset, and (SPI_SEQ_IRQ_EN) the interrupt.
module tb_spi_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_rx_en;
    logic [1:0]  cmd_csid;
    logic [4:0]  cmd_tx_sz, cmd_rx_sz;
    logic [31:0] cmd_data;
    logic        rx_valid, rx_pop, flush;
    logic [31:0] rx_data;
    logic [3:0]  cmd_count, rx_count;
    logic        idle, spi_tx, spi_rx_en, spi_done, spi_busy;
    logic [1:0]  spi_csid;
    logic [4:0]  spi_tx_sz, spi_rx_sz;
    logic [31:0] spi_tx_data, spi_rx;
`ifdef SPI_SEQ_IRQ_EN
    logic [3:0]  rx_thresh;
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    spi_seq #(.MAXID(4), .DEPTH(8)) dut (
`ifdef SPI_SEQ_IRQ_EN
        .rx_thresh_i  (rx_thresh),
        .irq_o        (irq),
`endif
        .spi_clock_i  (clk),
        .spi_reset_ni (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_csid_i   (cmd_csid),
        .cmd_tx_sz_i  (cmd_tx_sz),
        .cmd_rx_sz_i  (cmd_rx_sz),
        .cmd_rx_en_i  (cmd_rx_en),
        .cmd_data_i   (cmd_data),
        .rx_valid_o   (rx_valid),
        .rx_pop_i     (rx_pop),
        .rx_data_o    (rx_data),
        .flush_i      (flush),
        .cmd_count_o  (cmd_count),
        .rx_count_o   (rx_count),
        .idle_o       (idle),
        .spi_tx_o     (spi_tx),
        .spi_csid_o   (spi_csid),
        .spi_tx_sz_o  (spi_tx_sz),
        .spi_rx_sz_o  (spi_rx_sz),
        .spi_rx_en_o  (spi_rx_en),
        .spi_tx_data_o(spi_tx_data),
        .spi_done_i   (spi_done),
        .spi_busy_i   (spi_busy),
        .spi_rx_i     (spi_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        valid;
        logic [1:0]  csid;
        logic [4:0]  tx_sz;
        logic        rx_en;
        logic [31:0] data;
        logic        done;
        logic [31:0] rx;
        logic        pop;
        logic        e_ready;
        logic        e_tx;
        logic [1:0]  e_csid;
        logic [4:0]  e_tx_sz;
        logic        e_rx_en;
        logic [31:0] e_tx_data;
        logic [3:0]  e_cmd_cnt;
        logic [3:0]  e_rx_cnt;
        logic        e_idle;
        logic        e_rx_valid;
        logic [31:0] e_rx_data;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input logic [4:0] ts, input logic [4:0] rs,
                        input logic re, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_csid = c; cmd_tx_sz = ts; cmd_rx_sz = rs; cmd_rx_en = re; cmd_data = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic done_pulse(input logic [31:0] r);
        spi_done = 1'b1; spi_rx = r;
        step();
        spi_done = 1'b0; spi_rx = '0;
    endtask

    task automatic pop_one();
        rx_pop = 1'b1;
        step();
        rx_pop = 1'b0;
    endtask

    task automatic wait_tx(input int max, input string nm);
        int n = 0;
        while (!spi_tx && n < max) begin
            step();
            n++;
        end
        chk(nm, {31'd0, spi_tx}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 0; cmd_csid = 0; cmd_tx_sz = 0; cmd_rx_sz = 0; cmd_rx_en = 0;
        cmd_data = 0; rx_pop = 0; flush = 0; spi_done = 0; spi_busy = 0; spi_rx = 0;
`ifdef SPI_SEQ_IRQ_EN
        rx_thresh = 0;
`endif
        //             valid csid tx rxen data          done rx            pop | rdy tx csid txsz rxen txdata        cmd rx idle rxv rxdata
        vecs[0]  = '{1, 2, 7, 0, 32'hA5,       0, 0,            0,  1, 0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0,            0, 0,            0,  1, 1, 2, 7, 0, 32'hA5,       1, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0,            0, 0,            0,  1, 0, 2, 7, 0, 32'hA5,       1, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0,            0, 0,            0,  1, 0, 2, 7, 0, 32'hA5,       1, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0,            1, 32'hDEAD,     0,  1, 0, 2, 7, 0, 32'hA5,       0, 0, 1, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0,            1, 32'hBEEF,     0,  1, 0, 2, 7, 0, 32'hA5,       0, 0, 1, 0, 0};
        vecs[6]  = '{1, 1, 3, 1, 32'h11111111, 0, 0,            0,  1, 0, 2, 7, 0, 32'hA5,       1, 0, 0, 0, 0};
        vecs[7]  = '{1, 3, 9, 0, 32'h22222222, 0, 0,            0,  1, 1, 1, 3, 1, 32'h11111111, 2, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0,            0, 0,            0,  1, 0, 1, 3, 1, 32'h11111111, 2, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0,            1, 32'hCAFEF00D, 0,  1, 0, 1, 3, 1, 32'h11111111, 1, 1, 0, 1, 32'hCAFEF00D};
        vecs[10] = '{0, 0, 0, 0, 0,            0, 0,            0,  1, 1, 3, 9, 0, 32'h22222222, 1, 1, 0, 1, 32'hCAFEF00D};
        vecs[11] = '{0, 0, 0, 0, 0,            1, 32'h0,        0,  1, 0, 3, 9, 0, 32'h22222222, 1, 1, 0, 1, 32'hCAFEF00D};
        vecs[12] = '{0, 0, 0, 0, 0,            1, 32'hBAD,      0,  1, 0, 3, 9, 0, 32'h22222222, 0, 1, 1, 1, 32'hCAFEF00D};
        vecs[13] = '{0, 0, 0, 0, 0,            0, 0,            1,  1, 0, 3, 9, 0, 32'h22222222, 0, 0, 1, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 0,            0, 0,            1,  1, 0, 3, 9, 0, 32'h22222222, 0, 0, 1, 0, 0};

        step(); step();
        chk("rst_ready", {31'd0, cmd_ready}, 1);
        chk("rst_tx", {31'd0, spi_tx}, 0);
        chk("rst_idle", {31'd0, idle}, 1);
        chk("rst_cmd_cnt", {28'd0, cmd_count}, 0);
        chk("rst_rx_cnt", {28'd0, rx_count}, 0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 0);
        chk("rst_data", spi_tx_data, 0);
        rst_n = 1'b1;
        step();

        // cycle table: single issue, hold, stray done, capture, back-to-back spacing, pops
        for (int i = 0; i < 15; i++) begin
            cmd_valid = vecs[i].valid; cmd_csid = vecs[i].csid; cmd_tx_sz = vecs[i].tx_sz;
            cmd_rx_sz = 5'd0; cmd_rx_en = vecs[i].rx_en; cmd_data = vecs[i].data;
            spi_done = vecs[i].done; spi_rx = vecs[i].rx; rx_pop = vecs[i].pop;
            step();
            chk($sformatf("v%0d_ready", i), {31'd0, cmd_ready}, {31'd0, vecs[i].e_ready});
            chk($sformatf("v%0d_tx", i), {31'd0, spi_tx}, {31'd0, vecs[i].e_tx});
            chk($sformatf("v%0d_csid", i), {30'd0, spi_csid}, {30'd0, vecs[i].e_csid});
            chk($sformatf("v%0d_tx_sz", i), {27'd0, spi_tx_sz}, {27'd0, vecs[i].e_tx_sz});
            chk($sformatf("v%0d_rx_en", i), {31'd0, spi_rx_en}, {31'd0, vecs[i].e_rx_en});
            chk($sformatf("v%0d_txdata", i), spi_tx_data, vecs[i].e_tx_data);
            chk($sformatf("v%0d_cmd_cnt", i), {28'd0, cmd_count}, {28'd0, vecs[i].e_cmd_cnt});
            chk($sformatf("v%0d_rx_cnt", i), {28'd0, rx_count}, {28'd0, vecs[i].e_rx_cnt});
            chk($sformatf("v%0d_idle", i), {31'd0, idle}, {31'd0, vecs[i].e_idle});
            chk($sformatf("v%0d_rx_valid", i), {31'd0, rx_valid}, {31'd0, vecs[i].e_rx_valid});
            if (vecs[i].e_rx_valid)
                chk($sformatf("v%0d_rxdata", i), rx_data, vecs[i].e_rx_data);
            $display("vector %0d tx=%0b csid=%0d cmd=%0d rx=%0d idle=%0b", i, spi_tx, spi_csid, cmd_count, rx_count, idle);
        end
        cmd_valid = 0; spi_done = 0; rx_pop = 0; spi_rx = 0;

        // fill CMD FIFO while PHY busy; 9th push must be dropped
        spi_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                chk("fill_ready_full", {31'd0, cmd_ready}, 0);
                chk("fill_cnt8", {28'd0, cmd_count}, 8);
            end
            push(2'(i), 5'd4, 5'(i + 1), 1'b1, 32'd100 + 32'(i));
        end
        chk("fill_9th_dropped", {28'd0, cmd_count}, 8);
        chk("fill_no_tx", {31'd0, spi_tx}, 0);
        spi_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_tx(5, $sformatf("fill_tx%0d", i));
            chk($sformatf("fill_data%0d", i), spi_tx_data, 32'd100 + 32'(i));
            chk($sformatf("fill_csid%0d", i), {30'd0, spi_csid}, 32'(i % 4));
            chk($sformatf("fill_rxsz%0d", i), {27'd0, spi_rx_sz}, 32'(i + 1));
            step();
            done_pulse(32'(i));
            $display("fill transfer %0d data=%h rx_cnt=%0d", i, spi_tx_data, rx_count);
        end
        chk("fill_rx_cnt8", {28'd0, rx_count}, 8);
        chk("fill_idle", {31'd0, idle}, 1);

        // RX full: rx_en command must wait, and the rx_en=0 one queues behind it
        push(2'd1, 5'd2, 5'd2, 1'b1, 32'h300);
        push(2'd2, 5'd2, 5'd2, 1'b0, 32'h301);
        begin
            int seen = 0;
            repeat (6) begin
                step();
                if (spi_tx) seen++;
            end
            chk("rxfull_blocked", 32'(seen), 0);
        end
        chk("rxfull_cmd_cnt", {28'd0, cmd_count}, 2);
        chk("rxfull_head", rx_data, 0);
        pop_one();
        chk("rxfull_popped_cnt", {28'd0, rx_count}, 7);
        wait_tx(5, "rxfull_tx_after_pop");
        chk("rxfull_order0", spi_tx_data, 32'h300);
        step();
        done_pulse(32'h55);
        wait_tx(5, "rxfull_tx2");
        chk("rxfull_order1", spi_tx_data, 32'h301);
        step();
        done_pulse(32'hBAD);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("drain_rx%0d", i), rx_data, 32'(i));
            pop_one();
        end
        chk("drain_rx55", rx_data, 32'h55);
        pop_one();
        chk("drain_empty", {28'd0, rx_count}, 0);
        $display("rx reservation sequence complete");

        // flush while WAIT with 3 queued and one RX word
        push(2'd0, 5'd1, 5'd1, 1'b1, 32'h400);
        wait_tx(5, "fl_pre_tx");
        step();
        done_pulse(32'h4AA);
        chk("fl_pre_rx", {28'd0, rx_count}, 1);
        spi_busy = 1'b1;
        push(2'd1, 5'd1, 5'd1, 1'b1, 32'h401);
        push(2'd1, 5'd1, 5'd1, 1'b1, 32'h402);
        push(2'd1, 5'd1, 5'd1, 1'b1, 32'h403);
        spi_busy = 1'b0;
        wait_tx(5, "fl_tx");
        step();
        chk("fl_wait_cnt", {28'd0, cmd_count}, 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_cmd_cnt0", {28'd0, cmd_count}, 0);
        chk("fl_rx_cnt0", {28'd0, rx_count}, 0);
        chk("fl_drain_ready", {31'd0, cmd_ready}, 0);
        chk("fl_drain_notidle", {31'd0, idle}, 0);
        push(2'd3, 5'd1, 5'd1, 1'b1, 32'h4FF);
        chk("fl_drain_push_dropped", {28'd0, cmd_count}, 0);
        done_pulse(32'h777);
        chk("fl_late_done_rx", {28'd0, rx_count}, 0);
        chk("fl_idle", {31'd0, idle}, 1);
        chk("fl_ready", {31'd0, cmd_ready}, 1);
        push(2'd2, 5'd1, 5'd1, 1'b1, 32'h500);
        wait_tx(5, "fl_next_tx");
        chk("fl_next_data", spi_tx_data, 32'h500);
        step();
        done_pulse(32'h501);
        chk("fl_next_rx", rx_data, 32'h501);
        chk("fl_next_rx_cnt", {28'd0, rx_count}, 1);
        $display("flush sequence complete");

        // asynchronous reset in WAIT
        push(2'd3, 5'd6, 5'd6, 1'b1, 32'h600);
        wait_tx(5, "rs_tx");
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("rs_tx0", {31'd0, spi_tx}, 0);
        chk("rs_csid0", {30'd0, spi_csid}, 0);
        chk("rs_data0", spi_tx_data, 0);
        chk("rs_cmd0", {28'd0, cmd_count}, 0);
        chk("rs_rx0", {28'd0, rx_count}, 0);
        chk("rs_idle", {31'd0, idle}, 1);
        chk("rs_ready", {31'd0, cmd_ready}, 1);
        step();
        rst_n = 1'b1;
        done_pulse(32'h999);
        chk("rs_stray_rx", {28'd0, rx_count}, 0);
        chk("rs_stray_idle", {31'd0, idle}, 1);
        $display("reset sequence complete");

`ifdef SPI_SEQ_IRQ_EN
        rx_thresh = 4'd3;
        spi_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(2'd0, 5'd1, 5'd1, 1'b1, 32'h700 + 32'(i));
        spi_busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_tx(5, $sformatf("irq_tx%0d", k));
            step();
            done_pulse(32'h60 + 32'(k));
            if (k == 1) chk("irq_low_at2", {31'd0, irq}, 0);
        end
        spi_busy = 1'b1;
        chk("irq_high_at3", {31'd0, irq}, 1);
        pop_one();
        chk("irq_low_after_pop", {31'd0, irq}, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        spi_busy = 1'b0;
        rx_thresh = 4'd0;
        $display("irq sequence complete");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
